// File: rtl/mod_a_arb_pkg.sv
// Shared types and constants for the mod_a request arbiter.
// This package also holds the index-width helper that the arbiter modules use.
package mod_a_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int MAX_N = 16;

  // A single requester still needs a 1-bit index so that port widths stay legal.
  function automatic int calc_idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_a.sv
// Shared combinational compute unit that the arbiter time-multiplexes.
module mod_a (
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  output logic out1,
  output logic out2
);

  assign out1 = (in1 & in2) | (in3 & in4);
  assign out2 = in1 ^ in2 ^ in3 ^ in4;

endmodule

// File: rtl/mod_a_arbiter_rr_pick.sv
// Combinational round-robin picker. It grants the lowest requester at or above ptr.
// If no requester qualifies, it wraps to the lowest requester overall.
module rr_pick
  import mod_a_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [IDW-1:0] hi_id_s;
  logic [IDW-1:0] lo_id_s;
  logic           hi_any_s;
  logic           lo_any_s;
  logic           hit_s;

  // The scan runs downward, so the last hit found is the lowest index in each region.
  always_comb begin
    hi_id_s  = '0;
    lo_id_s  = '0;
    hi_any_s = 1'b0;
    lo_any_s = 1'b0;
    hit_s    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      hit_s    = req[i] && (IDW'(i) >= ptr);
      lo_id_s  = req[i] ? IDW'(i) : lo_id_s;
      lo_any_s = lo_any_s | req[i];
      hi_id_s  = hit_s ? IDW'(i) : hi_id_s;
      hi_any_s = hi_any_s | hit_s;
    end
  end

  // Prefer the region at or above the pointer, then fall back to the wrapped region.
  always_comb begin
    gnt_id = hi_any_s ? hi_id_s : lo_id_s;
    any    = lo_any_s;
    if (lo_any_s) begin
      gnt_onehot = N'(1'b1) << gnt_id;
    end else begin
      gnt_onehot = '0;
    end
  end

endmodule

// File: rtl/mod_a_arbiter.sv
// Round-robin front end that shares one mod_a among N valid/ready requesters.
// Each result is returned tagged with the index of its owner.
module mod_a_arbiter
  import mod_a_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = calc_idw(N)
) (
  input  logic           clk,
  input  logic           areset,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  input  logic [N-1:0]   req_c,
  input  logic [N-1:0]   req_d,
  output logic [N-1:0]   req_ready,
  output logic           resp_valid,
  output logic [IDW-1:0] resp_id,
  output logic           resp_out1,
  output logic           resp_out2,
  input  logic           resp_ready,
  output logic           busy
);

  arb_state_t     state_r, state_n;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] cur_id_r;
  logic           op_a_r, op_b_r, op_c_r, op_d_r;
  logic [N-1:0]   gnt_onehot_s;
  logic [IDW-1:0] gnt_id_s;
  logic           any_s;
  logic           out1_s, out2_s;
  logic [IDW-1:0] next_ptr_s;

  rr_pick #(.N(N)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_id     (gnt_id_s),
    .any        (any_s)
  );

  mod_a u_mod_a (
    .in1  (op_a_r),
    .in2  (op_b_r),
    .in3  (op_c_r),
    .in4  (op_d_r),
    .out1 (out1_s),
    .out2 (out2_s)
  );

  assign next_ptr_s = (cur_id_r == IDW'(N - 1)) ? '0 : cur_id_r + IDW'(1);

  // Next-state decode and the grant. The grant is also blocked while reset is asserted.
  always_comb begin
    state_n   = state_r;
    req_ready = '0;
    case (state_r)
      IDLE: begin
        if (any_s && !areset) begin
          req_ready = gnt_onehot_s;
          state_n   = EVAL;
        end else begin
          state_n   = IDLE;
        end
      end
      EVAL: state_n = RESP;
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, operand capture, result capture and pointer advance.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      cur_id_r   <= '0;
      op_a_r     <= 1'b0;
      op_b_r     <= 1'b0;
      op_c_r     <= 1'b0;
      op_d_r     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_out1  <= 1'b0;
      resp_out2  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r <= state_n;
      busy    <= (state_n != IDLE);
      case (state_r)
        IDLE: begin
          if (any_s) begin
            op_a_r   <= req_a[gnt_id_s];
            op_b_r   <= req_b[gnt_id_s];
            op_c_r   <= req_c[gnt_id_s];
            op_d_r   <= req_d[gnt_id_s];
            cur_id_r <= gnt_id_s;
          end
        end
        EVAL: begin
          resp_out1  <= out1_s;
          resp_out2  <= out2_s;
          resp_id    <= cur_id_r;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr_r   <= next_ptr_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_a_arbiter.sv
// Directed bench for mod_a_arbiter. It uses one N=4 instance and one N=3 instance.
// A bench-side reference of mod_a supplies the expected results.
module tb_mod_a_arbiter;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] v4 = 4'b0, a4 = 4'b0, b4 = 4'b0, c4 = 4'b0, d4 = 4'b0;
  logic [3:0] rdy4;
  logic       rv4, o1_4, o2_4, rr4 = 1'b0, busy4;
  logic [1:0] id4;
  logic [2:0] v3 = 3'b0, a3 = 3'b0, b3 = 3'b0, c3 = 3'b0, d3 = 3'b0;
  logic [2:0] rdy3;
  logic       rv3, o1_3, o2_3, rr3 = 1'b0, busy3;
  logic [1:0] id3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mod_a_arbiter #(.N(4)) dut4 (
    .clk(clk), .areset(areset), .req_valid(v4), .req_a(a4), .req_b(b4), .req_c(c4),
    .req_d(d4), .req_ready(rdy4), .resp_valid(rv4), .resp_id(id4), .resp_out1(o1_4),
    .resp_out2(o2_4), .resp_ready(rr4), .busy(busy4)
  );

  mod_a_arbiter #(.N(3)) dut3 (
    .clk(clk), .areset(areset), .req_valid(v3), .req_a(a3), .req_b(b3), .req_c(c3),
    .req_d(d3), .req_ready(rdy3), .resp_valid(rv3), .resp_id(id3), .resp_out1(o1_3),
    .resp_out2(o2_3), .resp_ready(rr3), .busy(busy3)
  );

  function automatic logic ref_o1(input logic a, input logic b, input logic c, input logic d);
    return (a & b) | (c & d);
  endfunction

  function automatic logic ref_o2(input logic a, input logic b, input logic c, input logic d);
    return a ^ b ^ c ^ d;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
  endtask

  task automatic test_reset();
    v4 = 4'b1111; v3 = 3'b111;
    #1;
    tests++;
    if (rdy4 !== 4'b0 || rv4 !== 1'b0 || busy4 !== 1'b0 || id4 !== 2'd0 || o1_4 !== 1'b0 || o2_4 !== 1'b0)
      begin fails++; $display("FAIL reset_state: rdy=%b rv=%b busy=%b id=%0d o=%b%b required all zero", rdy4, rv4, busy4, id4, o1_4, o2_4); end
    @(posedge clk); #1;
    tests++;
    if (rdy4 !== 4'b0 || rv4 !== 1'b0 || busy4 !== 1'b0 || rdy3 !== 3'b0)
      begin fails++; $display("FAIL reset_held: rdy4=%b rv=%b busy=%b rdy3=%b required zero", rdy4, rv4, busy4, rdy3); end
    v4 = 4'b0; v3 = 3'b0;
    areset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy4 !== 1'b0 || rv4 !== 1'b0)
      begin fails++; $display("FAIL reset_release_idle: busy=%b rv=%b required 0 0", busy4, rv4); end
  endtask

  task automatic test_single();
    logic e1, e2;
    a4 = 4'b0100; b4 = 4'b0000; c4 = 4'b0100; d4 = 4'b0100;
    e1 = ref_o1(1'b1, 1'b0, 1'b1, 1'b1);
    e2 = ref_o2(1'b1, 1'b0, 1'b1, 1'b1);
    v4 = 4'b0100; rr4 = 1'b1;
    #1;
    tests++;
    if (rdy4 !== 4'b0100) begin fails++; $display("FAIL single_grant: rdy=%b required 0100", rdy4); end
    @(posedge clk); #1;
    v4 = 4'b0000;
    tests++;
    if (rv4 !== 1'b0 || busy4 !== 1'b1 || rdy4 !== 4'b0)
      begin fails++; $display("FAIL single_eval: rv=%b busy=%b rdy=%b required 0 1 0000", rv4, busy4, rdy4); end
    @(posedge clk); #1;
    tests++;
    if (rv4 !== 1'b1 || id4 !== 2'd2 || o1_4 !== e1 || o2_4 !== e2)
      begin fails++; $display("FAIL single_resp: rv=%b id=%0d o1=%b o2=%b required 1 2 %b %b", rv4, id4, o1_4, o2_4, e1, e2); end
    @(posedge clk); #1;
    tests++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0)
      begin fails++; $display("FAIL single_done: rv=%b busy=%b required 0 0", rv4, busy4); end
  endtask

  task automatic test_wrap();
    a4 = 4'b0001; b4 = 4'b0011; c4 = 4'b0010; d4 = 4'b0010;
    v4 = 4'b0011; rr4 = 1'b1;
    #1;
    tests++;
    if (rdy4 !== 4'b0001) begin fails++; $display("FAIL wrap_first: rdy=%b required 0001", rdy4); end
    @(posedge clk); #1;
    v4 = 4'b0010;
    @(posedge clk); #1;
    tests++;
    if (rv4 !== 1'b1 || id4 !== 2'd0 || o1_4 !== ref_o1(1'b1, 1'b1, 1'b0, 1'b0) || o2_4 !== ref_o2(1'b1, 1'b1, 1'b0, 1'b0))
      begin fails++; $display("FAIL wrap_resp0: rv=%b id=%0d o=%b%b required id 0", rv4, id4, o1_4, o2_4); end
    @(posedge clk); #1;
    tests++;
    if (rdy4 !== 4'b0010) begin fails++; $display("FAIL wrap_second: rdy=%b required 0010", rdy4); end
    @(posedge clk); #1;
    v4 = 4'b0000;
    @(posedge clk); #1;
    tests++;
    if (rv4 !== 1'b1 || id4 !== 2'd1 || o1_4 !== ref_o1(1'b0, 1'b1, 1'b1, 1'b1) || o2_4 !== ref_o2(1'b0, 1'b1, 1'b1, 1'b1))
      begin fails++; $display("FAIL wrap_resp1: rv=%b id=%0d o=%b%b required id 1", rv4, id4, o1_4, o2_4); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_rdy;
    int g;
    do_reset();
    a4 = 4'b1010; b4 = 4'b1100; c4 = 4'b0110; d4 = 4'b0011;
    v4 = 4'b1111; rr4 = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      g = order[cyc / 3];
      exp_rdy = (cyc % 3 == 0) ? (4'b0001 << g) : 4'b0000;
      tests++;
      if (rdy4 !== exp_rdy)
        begin fails++; $display("FAIL rr_grant cyc %0d: rdy=%b required %b", cyc, rdy4, exp_rdy); end
      if (cyc % 3 == 2) begin
        tests++;
        if (rv4 !== 1'b1 || id4 !== 2'(g) || o1_4 !== ref_o1(a4[g], b4[g], c4[g], d4[g]) || o2_4 !== ref_o2(a4[g], b4[g], c4[g], d4[g]))
          begin fails++; $display("FAIL rr_resp cyc %0d: rv=%b id=%0d o=%b%b required id %0d", cyc, rv4, id4, o1_4, o2_4, g); end
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_backpressure();
    logic e1, e2;
    e1 = ref_o1(a4[1], b4[1], c4[1], d4[1]);
    e2 = ref_o2(a4[1], b4[1], c4[1], d4[1]);
    rr4 = 1'b0;
    tests++;
    if (rdy4 !== 4'b0010) begin fails++; $display("FAIL bp_grant: rdy=%b required 0010", rdy4); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (rv4 !== 1'b1 || id4 !== 2'd1 || o1_4 !== e1 || o2_4 !== e2 || rdy4 !== 4'b0 || busy4 !== 1'b1)
        begin fails++; $display("FAIL bp_hold %0d: rv=%b id=%0d o=%b%b rdy=%b busy=%b required 1 1 %b%b 0000 1", k, rv4, id4, o1_4, o2_4, rdy4, busy4, e1, e2); end
      @(posedge clk); #1;
    end
    rr4 = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rv4 !== 1'b0 || rdy4 !== 4'b0100)
      begin fails++; $display("FAIL bp_release: rv=%b rdy=%b required 0 0100", rv4, rdy4); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rr4 = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (rv4 !== 1'b1 || id4 !== 2'd2)
      begin fails++; $display("FAIL mid_setup: rv=%b id=%0d required 1 2", rv4, id4); end
    areset = 1'b1;
    #1;
    tests++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0 || rdy4 !== 4'b0 || id4 !== 2'd0)
      begin fails++; $display("FAIL mid_reset: rv=%b busy=%b rdy=%b id=%0d required 0 0 0000 0", rv4, busy4, rdy4, id4); end
    @(posedge clk); #1;
    areset = 1'b0;
    rr4 = 1'b1;
    #1;
    tests++;
    if (rdy4 !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: rdy=%b required 0001", rdy4); end
    v4 = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_n3();
    int order[4] = '{0, 1, 2, 0};
    logic [2:0] exp_rdy;
    int g;
    a3 = 3'b101; b3 = 3'b110; c3 = 3'b011; d3 = 3'b001;
    v3 = 3'b111; rr3 = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      g = order[cyc / 3];
      exp_rdy = (cyc % 3 == 0) ? (3'b001 << g) : 3'b000;
      tests++;
      if (rdy3 !== exp_rdy)
        begin fails++; $display("FAIL n3_grant cyc %0d: rdy=%b required %b", cyc, rdy3, exp_rdy); end
      if (cyc % 3 == 2) begin
        tests++;
        if (rv3 !== 1'b1 || id3 !== 2'(g) || o1_3 !== ref_o1(a3[g], b3[g], c3[g], d3[g]) || o2_3 !== ref_o2(a3[g], b3[g], c3[g], d3[g]))
          begin fails++; $display("FAIL n3_resp cyc %0d: rv=%b id=%0d o=%b%b required id %0d", cyc, rv3, id3, o1_3, o2_3, g); end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_n3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
